// File: rtl/pair_gen_pkg.sv
// Shared definitions for the pair-generation sequencer: FSM encoding and default sizes.
package pair_gen_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 8;
  localparam int NMAX   = 2**DEF_AW - 1;
  localparam int CW     = 2*DEF_AW;

  typedef logic [1:0] state_t;

  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_CALC  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/pair_skid_buf.sv
// Two-entry valid/ready buffer holding engine pairs; head entry drives the output.
module pair_skid_buf #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else if (push && pop) begin
      // Occupancy is unchanged; the incoming pair lands behind whatever remains.
      if (occ == 2'd1) begin
        head_q <= in_data;
      end else begin
        head_q <= tail_q;
        tail_q <= in_data;
      end
    end else if (pop) begin
      head_q <= tail_q;
      occ    <= occ - 2'd1;
    end else if (push) begin
      if (occ == 2'd0) head_q <= in_data;
      else             tail_q <= in_data;
      occ <= occ + 2'd1;
    end
  end

endmodule

// File: rtl/pair_gen_ctrl.sv
// Sequencer around the nested-for pair engine: loads one batch, drains all ordered pairs
// with backpressure, then clears the engine for the next batch.
module pair_gen_ctrl
  import pair_gen_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  // Streams: a beat transfers on a rising clk edge where valid & ready are both high;
  // valid never depends on ready, and data/last are held while valid waits for ready.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic            out_last,
  output logic            busy,
  output logic            err_overflow,
  output logic            fifo_clr,
  output logic            fifo_we,
  output logic [DW-1:0]   fifo_din,
  output logic            fifo_re,
  input  logic            fifo_valid,
  input  logic [2*DW-1:0] fifo_dout,
  output state_t          state_dbg
);

  localparam int            TW     = 2*AW;
  localparam logic [AW-1:0] ONE    = 1;
  localparam logic [AW-1:0] NMAX_L = '1;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] n_cnt;
  logic [TW-1:0] n_ext;
  logic [TW-1:0] total;
  logic [TW-1:0] issued;
  logic [TW-1:0] emitted;
  logic          inflight;
  logic          in_fire;
  logic          out_fire;
  logic          at_cap;
  logic          skid_push;
  logic          skid_in_ready;
  logic [1:0]    skid_occ;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign at_cap    = (n_cnt == NMAX_L - ONE);
  assign n_ext     = TW'(n_cnt);
  assign skid_push = (state == ST_DRAIN) & fifo_valid;
  assign state_dbg = state;

  always_comb begin
    in_ready     = (state == ST_LOAD);
    busy         = (state != ST_LOAD);
    fifo_clr     = (state == ST_CLEAR);
    fifo_we      = in_fire;
    fifo_din     = in_fire ? in_data : '0;
    err_overflow = in_fire & at_cap & ~in_last;
    // One read may be in flight, so reserve skid room for it before issuing another.
    fifo_re      = (state == ST_DRAIN) && (issued < total) && skid_in_ready &&
                   (({1'b0, skid_occ} + {2'b00, inflight}) < 3'd2);
    out_last     = out_valid && (emitted == total - TW'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: state_nxt = ST_LOAD;
      ST_LOAD:  if (in_fire && (in_last || at_cap)) state_nxt = ST_CALC;
      ST_CALC:  state_nxt = (n_cnt <= ONE) ? ST_CLEAR : ST_DRAIN;
      ST_DRAIN: if (out_fire && out_last) state_nxt = ST_CLEAR;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_CLEAR;
      n_cnt    <= '0;
      total    <= '0;
      issued   <= '0;
      emitted  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_re;
      case (state)
        ST_CLEAR: begin
          n_cnt   <= '0;
          issued  <= '0;
          emitted <= '0;
        end
        ST_LOAD: if (in_fire) n_cnt <= n_cnt + ONE;
        ST_CALC: total <= (n_ext * (n_ext - TW'(1))) >> 1;
        ST_DRAIN: begin
          if (fifo_re)  issued  <= issued + TW'(1);
          if (out_fire) emitted <= emitted + TW'(1);
        end
        default: ;
      endcase
    end
  end

  pair_skid_buf #(.W(2*DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_clr),
    .in_valid  (skid_push),
    .in_ready  (skid_in_ready),
    .in_data   (fifo_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (skid_occ)
  );

endmodule

// File: tb/tb_pair_gen_ctrl.sv
// Bench for pair_gen_ctrl with a behavioural nested-for pair engine and a pair scoreboard.
module tb_pair_gen_ctrl;
  import pair_gen_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NMX  = 2**AW - 1;
  localparam int W    = 2*DW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*DW-1:0] out_data;
  logic            out_last;
  logic            busy;
  logic            err_overflow;
  logic            fifo_clr;
  logic            fifo_we;
  logic [DW-1:0]   fifo_din;
  logic            fifo_re;
  logic            fifo_valid = 1'b0;
  logic [2*DW-1:0] fifo_dout = '0;
  state_t          state_dbg;

  pair_gen_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_overflow(err_overflow),
    .fifo_clr(fifo_clr), .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_re(fifo_re),
    .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .state_dbg(state_dbg)
  );

  // engine model: stores elements, emits pairs (i<j) in nested-for order one cycle after re
  logic [DW-1:0] eng_mem [0:7];
  int eng_cnt = 0;
  int eng_i   = 0;
  int eng_j   = 1;

  always @(posedge clk) begin
    if (fifo_clr) begin
      eng_cnt    <= 0;
      eng_i      <= 0;
      eng_j      <= 1;
      fifo_valid <= 1'b0;
    end else begin
      fifo_valid <= 1'b0;
      if (fifo_we && eng_cnt < 8) begin
        eng_mem[eng_cnt] <= fifo_din;
        eng_cnt          <= eng_cnt + 1;
      end
      if (fifo_re && eng_j < eng_cnt) begin
        fifo_dout  <= {eng_mem[eng_j], eng_mem[eng_i]};
        fifo_valid <= 1'b1;
        if (eng_j + 1 < eng_cnt) eng_j <= eng_j + 1;
        else begin
          eng_i <= eng_i + 1;
          eng_j <= eng_i + 2;
        end
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [8:0]   beats[$];
  int pairs_seen = 0;
  int ovf_cnt    = 0;
  int clr_cnt    = 0;
  int ready_mode = 0;
  int pat_i      = 0;
  bit gap_en     = 1'b0;
  logic [3:0] ready_pat = 4'b1001;
  logic            prev_stall = 1'b0;
  logic [2*DW-1:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // consumer: drives out_ready and scores every pair handshake
  always @(negedge clk) begin
    if (rst) begin
      out_ready  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1: begin
          out_ready = ready_pat[3 - pat_i];
          pat_i     = (pat_i + 1) % 4;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && out_valid) check("stall_hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pair", exp_q.size(), 1);
        else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("pair_data", out_data, e[2*DW-1:0]);
          check("pair_last", out_last, e[W-1]);
        end
        pairs_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // strobe monitor, sampled mid-low-phase once inputs have settled
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      int n;
      n = int'(fifo_clr) + int'(fifo_re) + int'(fifo_we);
      if (n > 1) check("strobe_excl", n, 1);
      if (err_overflow) ovf_cnt++;
      if (fifo_clr) clr_cnt++;
    end
  end

  // driver tasks
  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outs();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 1);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_fifo_clr", fifo_clr, 1);
    check("rst_fifo_we", fifo_we, 0);
    check("rst_fifo_din", fifo_din, 0);
    check("rst_fifo_re", fifo_re, 0);
    check("rst_state", state_dbg, ST_CLEAR);
  endtask

  task automatic drive_beats(output int accepted);
    accepted = 0;
    foreach (beats[k]) begin
      int t = 0;
      if (gap_en && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = beats[k][7:0];
      in_last  = beats[k][8];
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", t, 0);
        break;
      end
      @(negedge clk);
      accepted++;
      if (busy) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // reference: batch closes on the first last beat or at NMAX beats; all i<j pairs follow
  task automatic run_batch(output int cyc_to_load);
    logic [DW-1:0] elems[$];
    int acc_exp = 0;
    int ovf_exp = 0;
    int acc, n_pairs, k;
    int p0, o0, c0, t;
    foreach (beats[b]) begin
      elems.push_back(beats[b][7:0]);
      acc_exp++;
      if (beats[b][8]) break;
      if (acc_exp == NMX) begin
        ovf_exp = 1;
        break;
      end
    end
    n_pairs = acc_exp * (acc_exp - 1) / 2;
    p0 = pairs_seen;
    o0 = ovf_cnt;
    c0 = clr_cnt;
    drive_beats(acc);
    check("accepted", acc, acc_exp);
    k = 0;
    for (int i = 0; i < acc_exp; i++)
      for (int j = i + 1; j < acc_exp; j++) begin
        k++;
        exp_q.push_back({1'(k == n_pairs), elems[j], elems[i]});
      end
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    cyc_to_load = t;
    check("batch_done_timeout", int'(t >= 3000), 0);
    check("pair_count", pairs_seen - p0, n_pairs);
    check("overflow_pulses", ovf_cnt - o0, ovf_exp);
    check("clr_pulses", clr_cnt - c0, 1);
    exp_q.delete();
    beats.delete();
  endtask

  initial begin
    int cyc, t;
    rst = 1'b1;
    #1;
    check_reset_outs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: four elements, consumer always ready
    ready_mode = 0;
    beats = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
    run_batch(cyc);

    // 2: same batch, consumer ready pattern 1,0,0,1
    ready_mode = 1;
    pat_i = 0;
    beats = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h1A4};
    run_batch(cyc);

    // 3: single element, no pairs, quickly back to LOAD
    ready_mode = 0;
    beats = '{9'h1B7};
    run_batch(cyc);
    check("single_reload_cycles", int'(cyc <= 3), 1);
    check("single_state_load", state_dbg, ST_LOAD);
    check("single_in_ready", in_ready, 1);

    // 4: nine beats without last, truncated at NMAX
    beats = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007, 9'h008, 9'h009};
    run_batch(cyc);

    // 5: reset in the middle of a drain
    beats = '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4};
    begin
      int acc;
      int p0;
      p0 = pairs_seen;
      drive_beats(acc);
      exp_q.push_back({1'b0, 8'hC2, 8'hC1});
      exp_q.push_back({1'b0, 8'hC3, 8'hC1});
      t = 0;
      while (pairs_seen - p0 < 2 && t < 200) begin
        @(negedge clk);
        #3;
        t++;
      end
      check("mid_drain_reached", pairs_seen - p0, 2);
      check("mid_drain_state", state_dbg, ST_DRAIN);
      rst = 1'b1;
      #1;
      check_reset_outs();
      exp_q.delete();
      beats.delete();
      @(negedge clk);
      check_reset_outs();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
    end
    beats = '{9'h001, 9'h102};
    run_batch(cyc);

    // 6: back-to-back batches
    beats = '{9'h011, 9'h022, 9'h133};
    run_batch(cyc);
    beats = '{9'h044, 9'h155};
    run_batch(cyc);

    // randomized batches, random gaps and backpressure
    ready_mode = 2;
    gap_en = 1'b1;
    for (int b = 0; b < 12; b++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++)
        beats.push_back({1'((k == len - 1) || ($urandom_range(0, 7) == 0)),
                         8'($urandom_range(0, 255))});
      run_batch(cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
